// File: rtl/eq_audio_pkg.sv
// Shared audio parameters and sample types for the equalizer datapath and the codec link.
package eq_audio_pkg;
  localparam int DATA_W    = 16;
  localparam int SLOT_W    = 32;
  localparam int SCLK_DIV  = 32;
  localparam int DIV_W     = $clog2(SCLK_DIV);
  localparam int SLOT_BITS = $clog2(SLOT_W);
  localparam int CNT_W     = DIV_W + SLOT_BITS + 1;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [SLOT_BITS-1:0]     per_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } smpl_pair_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// Frame counter producing MCLK/SCLK/LRCLK straight from counter flops, plus strobes that
// flag the clock edge at which the next SCLK fall / LRCLK rise / frame wrap happens.
module i2s_clk_gen
  import eq_audio_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic mclk,
  output logic sclk,
  output logic lrclk,
  output logic sclk_fall,
  output logic lr_rise,
  output logic frm_wrap,
  output per_t per_nxt,
  output logic lr_nxt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign mclk  = cnt_q[1];
  assign sclk  = cnt_q[DIV_W-1];
  assign lrclk = cnt_q[CNT_W-1];

  // Strobes are high in the cycle whose closing edge produces the event.
  assign sclk_fall = &cnt_q[DIV_W-1:0];
  assign frm_wrap  = &cnt_q;
  assign lr_rise   = (&cnt_q[CNT_W-2:0]) & ~cnt_q[CNT_W-1];
  assign per_nxt   = cnt_d[CNT_W-2:DIV_W];
  assign lr_nxt    = cnt_d[CNT_W-1];
endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter toward the CS4272: holding/active sample pair, per-channel shift registers,
// and the SDin mux with one-bit I2S delay; data changes only on SCLK falling edges.
module i2s_tx_serializer
  import eq_audio_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t lft_in,
  input  sample_t rht_in,
  input  logic    smpl_vld,
  output logic    frm_strt,
  output logic    undrn,
  output logic    MCLK,
  output logic    SCLK,
  output logic    LRCLK,
  output logic    SDin
);
  localparam per_t LAST_BIT = per_t'(DATA_W);

  logic sclk_fall, lr_rise, frm_wrap, lr_nxt;
  per_t per_nxt;

  i2s_clk_gen u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .mclk      (MCLK),
    .sclk      (SCLK),
    .lrclk     (LRCLK),
    .sclk_fall (sclk_fall),
    .lr_rise   (lr_rise),
    .frm_wrap  (frm_wrap),
    .per_nxt   (per_nxt),
    .lr_nxt    (lr_nxt)
  );

  smpl_pair_t hold_q, hold_d, act_q, act_d;
  sample_t    shl_q, shl_d, shr_q, shr_d;
  logic       vld_seen_q, vld_seen_d;
  logic       sdin_q, sdin_d;
  logic       frm_strt_q, frm_strt_d;
  logic       undrn_q, undrn_d;

  always_comb begin
    hold_d     = hold_q;
    act_d      = act_q;
    shl_d      = shl_q;
    shr_d      = shr_q;
    vld_seen_d = vld_seen_q;
    sdin_d     = sdin_q;
    frm_strt_d = 1'b0;
    undrn_d    = 1'b0;

    if (smpl_vld) hold_d = '{l: lft_in, r: rht_in};

    // Boundary copies the pre-update holding pair; a coincident strobe belongs to the next frame.
    if (frm_wrap) begin
      act_d      = hold_q;
      frm_strt_d = 1'b1;
      undrn_d    = ~vld_seen_q;
      vld_seen_d = 1'b0;
    end
    if (smpl_vld) vld_seen_d = 1'b1;

    if (sclk_fall) begin
      if (per_nxt == '0) begin
        sdin_d = 1'b0;
        if (frm_wrap) shl_d = hold_q.l;
        if (lr_rise)  shr_d = act_q.r;
      end else if (per_nxt <= LAST_BIT) begin
        if (lr_nxt) {sdin_d, shr_d} = {shr_q, 1'b0};
        else        {sdin_d, shl_d} = {shl_q, 1'b0};
      end else begin
        sdin_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      act_q      <= '0;
      shl_q      <= '0;
      shr_q      <= '0;
      vld_seen_q <= 1'b0;
      sdin_q     <= 1'b0;
      frm_strt_q <= 1'b0;
      undrn_q    <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      act_q      <= act_d;
      shl_q      <= shl_d;
      shr_q      <= shr_d;
      vld_seen_q <= vld_seen_d;
      sdin_q     <= sdin_d;
      frm_strt_q <= frm_strt_d;
      undrn_q    <= undrn_d;
    end
  end

  assign SDin     = sdin_q;
  assign frm_strt = frm_strt_q;
  assign undrn    = undrn_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer with a behavioural I2S receiver standing in for the codec.
module tb_i2s_tx_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lft_in = '0, rht_in = '0;
  logic        smpl_vld = 1'b0;
  logic        frm_strt, undrn, MCLK, SCLK, LRCLK, SDin;

  int n_chk = 0, n_pass = 0;

  i2s_tx_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .lft_in   (lft_in),
    .rht_in   (rht_in),
    .smpl_vld (smpl_vld),
    .frm_strt (frm_strt),
    .undrn    (undrn),
    .MCLK     (MCLK),
    .SCLK     (SCLK),
    .LRCLK    (LRCLK),
    .SDin     (SDin)
  );

  always #5 clk = ~clk;

  // Codec receiver: samples on SCLK rise; an LRCLK change marks the delay bit, then 16 data bits MSB-first.
  int          idx = -1, pad_err = 0, rframes = 0;
  logic        lr_prev = 1'b0;
  logic [15:0] sh = '0, aout_l = '0, aout_r = '0;
  int          nidx;
  logic [15:0] nsh;
  assign nidx = (LRCLK != lr_prev) ? 0 : idx + 1;
  assign nsh  = {sh[14:0], SDin};

  always @(posedge SCLK or posedge rst) begin
    if (rst) begin
      idx     <= -1;
      lr_prev <= 1'b0;
    end else begin
      idx     <= nidx;
      lr_prev <= LRCLK;
      if (nidx >= 1 && nidx <= 16) sh <= nsh;
      else if (SDin) pad_err <= pad_err + 1;
      if (nidx == 16) begin
        if (LRCLK) begin aout_r <= nsh; rframes <= rframes + 1; end
        else aout_l <= nsh;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic wait_frm();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frm_strt) break;
    end
    if (i == 3000) chk("frm_timeout", 0, 1);
  endtask

  // Called at a negedge; the strobe is sampled at the following posedge.
  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    smpl_vld = 1'b1; lft_in = l; rht_in = r;
    @(negedge clk);
    smpl_vld = 1'b0;
  endtask

  // First frame after reset release (called at the release negedge).
  task automatic run_frame0(input string tg);
    int fm = -1, fs = -1, fl = -1, ff = -1, ones = 0, srise = 0;
    logic u = 1'b0, sp = 1'b0;
    for (int n = 1; n <= 2048; n++) begin
      @(negedge clk);
      if (fm < 0 && MCLK)  fm = n;
      if (fs < 0 && SCLK)  fs = n;
      if (fl < 0 && LRCLK) fl = n;
      if (ff < 0 && frm_strt) begin ff = n; u = undrn; end
      if (SCLK && !sp) srise++;
      sp = SCLK;
      if (SDin) ones++;
    end
    chk({tg, "_mclk_rise"},  fm, 2);
    chk({tg, "_sclk_rise"},  fs, 16);
    chk({tg, "_lrclk_rise"}, fl, 1024);
    chk({tg, "_frm_strt"},   ff, 2048);
    chk({tg, "_undrn"},      u, 1);
    chk({tg, "_sclk_cnt"},   srise, 64);
    chk({tg, "_sdin_zero"},  ones, 0);
  endtask

  initial begin
    int r0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {SDin, MCLK, SCLK, LRCLK, frm_strt, undrn}, 0);
    rst = 1'b0;
    run_frame0("rel");
    wait_frm();
    chk("idle_undrn", undrn, 1);

    // Basic pair plus MSB latency of one SCLK period.
    repeat (100) @(negedge clk);
    strobe(16'hA5C3, 16'h5A3C);
    wait_frm();
    chk("a5_undrn", undrn, 0);
    chk("lat_p0", SDin, 0);
    repeat (31) @(negedge clk);
    chk("lat_p0_end", SDin, 0);
    @(negedge clk);
    chk("lat_msb", SDin, 1);
    repeat (32) @(negedge clk);
    chk("lat_b14", SDin, 0);
    wait_frm();
    chk("a5_aout_l", aout_l, 16'hA5C3);
    chk("a5_aout_r", aout_r, 16'h5A3C);
    chk("a5_pad", pad_err, 0);
    chk("a5_next_undrn", undrn, 1);

    // Underrun repeats the last pair.
    repeat (100) @(negedge clk);
    strobe(16'h1234, 16'h8001);
    wait_frm();
    chk("rep_undrn0", undrn, 0);
    r0 = rframes;
    for (int k = 0; k < 3; k++) begin
      wait_frm();
      chk("rep_undrn", undrn, 1);
      chk("rep_l", aout_l, 16'h1234);
      chk("rep_r", aout_r, 16'h8001);
      chk("rep_frames", rframes, r0 + k + 1);
    end

    // Strobe coincident with the frm_strt cycle.
    strobe(16'h7FFF, 16'h8000);
    wait_frm();
    chk("coin_undrn", undrn, 0);
    chk("coin_old_l", aout_l, 16'h1234);
    chk("coin_old_r", aout_r, 16'h8001);
    wait_frm();
    chk("coin_new_l", aout_l, 16'h7FFF);
    chk("coin_new_r", aout_r, 16'h8000);
    chk("coin_undrn2", undrn, 1);

    // Two strobes in one frame: last wins.
    repeat (200) @(negedge clk);
    strobe(16'h0001, 16'h0001);
    repeat (100) @(negedge clk);
    strobe(16'hFFFF, 16'hFFFF);
    wait_frm();
    chk("two_undrn", undrn, 0);
    wait_frm();
    chk("two_l", aout_l, 16'hFFFF);
    chk("two_r", aout_r, 16'hFFFF);
    chk("two_pad", pad_err, 0);

    // Reset in the middle of the right slot.
    repeat (1300) @(negedge clk);
    chk("mid_lrclk", LRCLK, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {SDin, MCLK, SCLK, LRCLK, frm_strt, undrn}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_frame0("rst2");
    chk("rst2_aout_l", aout_l, 0);
    chk("rst2_aout_r", aout_r, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
